spot_scheduler: RTL and testbench

SPOT_SCHEDULER -- requirements
Module: spot_scheduler

---
 rtl/spot_scheduler.sv | 160 ++++++++++++++++
 tb/tb_spot_scheduler.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spot_scheduler.sv
// Raster beam counter with four double-buffered spot descriptors.
// Two requesters share a round-robin write port into the shadow copies.

module spot_lane (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en_i,
    input  logic [2:0]  field_i,
    input  logic [10:0] data_i,
    input  logic        load_i,
    input  logic [10:0] h_i,
    input  logic [9:0]  v_i,
    output logic        hit_o
);
    typedef struct packed {
        logic [10:0] hpos;
        logic [9:0]  width;
        logic [9:0]  vpos;
        logic [9:0]  height;
        logic        en;
    } desc_t;

    desc_t       sh_q, ac_q;
    logic [11:0] h_end;
    logic [10:0] v_end;

    // The boundary load reads the pre-write shadow, so a same-clock write lands one frame later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q <= '0;
            ac_q <= '0;
        end else begin
            if (load_i) ac_q <= sh_q;
            if (wr_en_i) begin
                case (field_i)
                    3'd0:    sh_q.hpos   <= data_i;
                    3'd1:    sh_q.width  <= data_i[9:0];
                    3'd2:    sh_q.vpos   <= data_i[9:0];
                    3'd3:    sh_q.height <= data_i[9:0];
                    3'd4:    sh_q.en     <= data_i[0];
                    default: ;
                endcase
            end
        end
    end

    // One bit of headroom keeps hpos+width / vpos+height from wrapping.
    assign h_end = {1'b0, ac_q.hpos} + {2'b00, ac_q.width};
    assign v_end = {1'b0, ac_q.vpos} + {1'b0, ac_q.height};
    assign hit_o = ac_q.en
                && (ac_q.hpos < h_i) && ({1'b0, h_i} < h_end)
                && (ac_q.vpos < v_i) && ({1'b0, v_i} < v_end);
endmodule

module spot_scheduler #(
    parameter logic [10:0] H_TOTAL  = 11'd910,
    parameter logic [10:0] H_ACTIVE = 11'd720,
    parameter logic [10:0] H_SYNC   = 11'd64,
    parameter logic [9:0]  V_TOTAL  = 10'd525,
    parameter logic [9:0]  V_ACTIVE = 10'd480,
    parameter logic [9:0]  V_SYNC   = 10'd6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_a_valid,
    output logic        req_a_ready,
    input  logic [1:0]  req_a_idx,
    input  logic [2:0]  req_a_field,
    input  logic [10:0] req_a_data,
    input  logic        req_b_valid,
    output logic        req_b_ready,
    input  logic [1:0]  req_b_idx,
    input  logic [2:0]  req_b_field,
    input  logic [10:0] req_b_data,
    input  logic        enable_out,
    output logic [10:0] h_cnt,
    output logic [9:0]  v_cnt,
    output logic        hsync,
    output logic        vsync,
    output logic        blank,
    output logic [3:0]  spot_hit,
    output logic        video_out
);
    localparam int          NUM_SPOTS = 4;
    localparam logic [10:0] H_LAST    = H_TOTAL - 11'd1;
    localparam logic [9:0]  V_LAST    = V_TOTAL - 10'd1;

    typedef struct packed {
        logic [1:0]  idx;
        logic [2:0]  field;
        logic [10:0] data;
    } wr_req_t;

    logic [10:0]          h_cnt_q, h_cnt_d;
    logic [9:0]           v_cnt_q, v_cnt_d;
    logic                 last_b_q, last_b_d;
    logic [NUM_SPOTS-1:0] hit_q, hit_c, wr_sel;
    logic                 video_q, video_d;
    logic                 frame_end, wr_fire;
    wr_req_t              req_a, req_b, wr;

    assign req_a = '{idx: req_a_idx, field: req_a_field, data: req_a_data};
    assign req_b = '{idx: req_b_idx, field: req_b_field, data: req_b_data};

    // last_b_q == 1 means B was served last, so A wins the next contention.
    always_comb begin
        req_a_ready = req_a_valid && (!req_b_valid || last_b_q);
        req_b_ready = req_b_valid && (!req_a_valid || !last_b_q);
        wr_fire     = req_a_ready || req_b_ready;
        wr          = req_b_ready ? req_b : req_a;
        wr_sel      = wr_fire ? (NUM_SPOTS'(1) << wr.idx) : '0;
        last_b_d    = wr_fire ? req_b_ready : last_b_q;
    end

    always_comb begin
        frame_end = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
        h_cnt_d   = (h_cnt_q == H_LAST) ? 11'd0 : h_cnt_q + 11'd1;
        v_cnt_d   = v_cnt_q;
        if (h_cnt_q == H_LAST) v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
        video_d   = enable_out && (|hit_c);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt_q  <= '0;
            v_cnt_q  <= '0;
            last_b_q <= 1'b1;
            hit_q    <= '0;
            video_q  <= 1'b0;
        end else begin
            h_cnt_q  <= h_cnt_d;
            v_cnt_q  <= v_cnt_d;
            last_b_q <= last_b_d;
            hit_q    <= hit_c;
            video_q  <= video_d;
        end
    end

    for (genvar i = 0; i < NUM_SPOTS; i++) begin : g_spot
        spot_lane u_spot (
            .clk     (clk),
            .rst     (reset),
            .wr_en_i (wr_sel[i]),
            .field_i (wr.field),
            .data_i  (wr.data),
            .load_i  (frame_end),
            .h_i     (h_cnt_q),
            .v_i     (v_cnt_q),
            .hit_o   (hit_c[i])
        );
    end

    assign h_cnt     = h_cnt_q;
    assign v_cnt     = v_cnt_q;
    assign hsync     = h_cnt_q < H_SYNC;
    assign vsync     = v_cnt_q < V_SYNC;
    assign blank     = (h_cnt_q >= H_ACTIVE) || (v_cnt_q >= V_ACTIVE);
    assign spot_hit  = hit_q;
    assign video_out = video_q;
endmodule

// File: tb/tb_spot_scheduler.sv
// Directed bench for spot_scheduler on a reduced 120x60 raster so whole frames fit the run.

module tb_spot_scheduler;
    localparam int HT = 120, HA = 112, HS = 8, VT = 60, VA = 56, VS = 6;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0, reset;
    logic        req_a_valid, req_a_ready, req_b_valid, req_b_ready;
    logic [1:0]  req_a_idx, req_b_idx;
    logic [2:0]  req_a_field, req_b_field;
    logic [10:0] req_a_data, req_b_data;
    logic        enable_out, hsync, vsync, blank, video_out;
    logic [10:0] h_cnt;
    logic [9:0]  v_cnt;
    logic [3:0]  spot_hit;

    typedef struct { int hp; int w; int vp; int ht; int en; } desc_t;
    desc_t shd[4], act[4];
    int n_vec = 0, n_err = 0, mism = 0;
    int mh, mv;
    int hitcnt[4];

    always #5 clk = ~clk;

    spot_scheduler #(
        .H_TOTAL(11'd120), .H_ACTIVE(11'd112), .H_SYNC(11'd8),
        .V_TOTAL(10'd60), .V_ACTIVE(10'd56), .V_SYNC(10'd6)
    ) dut (
        .clk(clk), .reset(reset),
        .req_a_valid(req_a_valid), .req_a_ready(req_a_ready), .req_a_idx(req_a_idx),
        .req_a_field(req_a_field), .req_a_data(req_a_data),
        .req_b_valid(req_b_valid), .req_b_ready(req_b_ready), .req_b_idx(req_b_idx),
        .req_b_field(req_b_field), .req_b_data(req_b_data),
        .enable_out(enable_out), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .hsync(hsync), .vsync(vsync), .blank(blank),
        .spot_hit(spot_hit), .video_out(video_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_hits(input int h, input int v);
        logic [3:0] r = '0;
        for (int i = 0; i < 4; i++)
            r[i] = (act[i].en != 0) && (act[i].hp < h) && (h < act[i].hp + act[i].w)
                && (act[i].vp < v) && (v < act[i].vp + act[i].ht);
        return r;
    endfunction

    task automatic clear_model();
        mh = 0; mv = 0;
        for (int i = 0; i < 4; i++) begin
            shd[i] = '{0, 0, 0, 0, 0};
            act[i] = '{0, 0, 0, 0, 0};
        end
    endtask

    // One clock; every output is compared with the reference raster and hit rectangles.
    task automatic step();
        int ph = mh, pv = mv;
        logic pe = enable_out;
        logic [3:0] e;
        @(posedge clk); #1;
        e = exp_hits(ph, pv);
        if (ph == HT - 1 && pv == VT - 1)
            for (int i = 0; i < 4; i++) act[i] = shd[i];
        mh = (mh == HT - 1) ? 0 : mh + 1;
        if (ph == HT - 1) mv = (mv == VT - 1) ? 0 : mv + 1;
        if (h_cnt !== 11'(mh) || v_cnt !== 10'(mv) || spot_hit !== e
            || video_out !== (pe && (|e)) || hsync !== (mh < HS) || vsync !== (mv < VS)
            || blank !== (mh >= HA || mv >= VA)) mism++;
        for (int i = 0; i < 4; i++) if (spot_hit[i] === 1'b1) hitcnt[i]++;
    endtask

    task automatic step_to(input int h, input int v);
        int n = 0;
        while (!(mh == h && mv == v) && n < FRAME + 10) begin step(); n++; end
        if (n >= FRAME + 10) mism++;
    endtask

    task automatic wr(input bit use_b, input int idx, input int fld, input int data);
        if (use_b) begin
            req_b_valid = 1'b1; req_b_idx = 2'(idx); req_b_field = 3'(fld); req_b_data = 11'(data);
        end else begin
            req_a_valid = 1'b1; req_a_idx = 2'(idx); req_a_field = 3'(fld); req_a_data = 11'(data);
        end
        #1;
        if ((use_b ? req_b_ready : req_a_ready) !== 1'b1) mism++;
        step();
        req_a_valid = 1'b0; req_b_valid = 1'b0;
        case (fld)
            0: shd[idx].hp = data & 'h7ff;
            1: shd[idx].w  = data & 'h3ff;
            2: shd[idx].vp = data & 'h3ff;
            3: shd[idx].ht = data & 'h3ff;
            4: shd[idx].en = data & 1;
            default: ;
        endcase
    endtask

    task automatic clr_hits();
        for (int i = 0; i < 4; i++) hitcnt[i] = 0;
    endtask

    initial begin
        int zc, hs_n, vs_n, bl_n;
        reset = 1'b1; enable_out = 1'b1;
        req_a_valid = 1'b0; req_a_idx = '0; req_a_field = '0; req_a_data = '0;
        req_b_valid = 1'b0; req_b_idx = '0; req_b_field = '0; req_b_data = '0;
        clear_model(); clr_hits();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_h", 32'(h_cnt), 0);
        chk("rst_v", 32'(v_cnt), 0);
        chk("rst_hit", 32'(spot_hit), 0);
        chk("rst_video", 32'(video_out), 0);
        chk("rst_hsync", 32'(hsync), 1);
        chk("rst_vsync", 32'(vsync), 1);
        chk("rst_blank", 32'(blank), 0);
        chk("rst_ready", 32'({req_a_ready, req_b_ready}), 0);

        reset = 1'b0;
        step();
        chk("h_after_release", 32'(h_cnt), 1);

        // Full frame scan: one wrap to (0,0) and strobe totals for 120x60 timing.
        zc = 0; hs_n = 0; vs_n = 0; bl_n = 0; mism = 0;
        for (int i = 0; i < FRAME; i++) begin
            step();
            if (h_cnt == 0 && v_cnt == 0) zc++;
            hs_n += 32'(hsync); vs_n += 32'(vsync); bl_n += 32'(blank);
        end
        chk("wrap_once", 32'(zc), 1);
        chk("hsync_clocks", 32'(hs_n), 480);
        chk("vsync_clocks", 32'(vs_n), 720);
        chk("blank_clocks", 32'(bl_n), 928);
        chk("frame_end_h", 32'(h_cnt), 1);
        chk("scan_model", 32'(mism), 0);

        // Contention alternates starting with A; field 7 writes nothing.
        req_a_valid = 1'b1; req_b_valid = 1'b1;
        req_a_field = 3'd7; req_b_field = 3'd7; req_a_data = 11'h7ff; req_b_data = 11'h7ff;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("arb_a%0d", k), 32'(req_a_ready), 32'(k % 2 == 0));
            chk($sformatf("arb_b%0d", k), 32'(req_b_ready), 32'(k % 2 == 1));
            step();
        end
        req_a_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("solo_b%0d", k), 32'({req_a_ready, req_b_ready}), 1);
            step();
        end
        req_b_valid = 1'b0;
        #1;
        chk("idle_ready", 32'({req_a_ready, req_b_ready}), 0);
        req_a_valid = 1'b1; req_b_valid = 1'b1;
        #1;
        chk("after_b_a_wins", 32'({req_a_ready, req_b_ready}), 2);
        req_a_valid = 1'b0; req_b_valid = 1'b0;

        // Spot0 written mid-frame: invisible until the next frame.
        mism = 0;
        wr(0, 0, 0, 100); wr(0, 0, 1, 10); wr(0, 0, 2, 50); wr(0, 0, 3, 4); wr(0, 0, 4, 1);
        clr_hits();
        step_to(0, 0);
        chk("no_hit_cur_frame", 32'(hitcnt[0]), 0);
        chk("cur_frame_model", 32'(mism), 0);

        clr_hits(); mism = 0;
        step_to(101, 51);
        chk("hit_lead_edge", 32'(spot_hit), 0);
        step();
        chk("hit_first", 32'(spot_hit), 1);
        chk("video_first", 32'(video_out), 1);
        step_to(110, 53);
        chk("hit_last", 32'(spot_hit), 1);
        step();
        chk("hit_trail", 32'(spot_hit), 0);
        wr(0, 1, 0, 2000); wr(0, 1, 1, 100); wr(0, 1, 2, 1000); wr(0, 1, 3, 100); wr(0, 1, 4, 1);
        wr(1, 2, 0, 10); wr(1, 2, 1, 1); wr(1, 2, 2, 10); wr(1, 2, 3, 20); wr(1, 2, 4, 1);
        wr(1, 3, 0, 10); wr(1, 3, 1, 20); wr(1, 3, 2, 10); wr(1, 3, 3, 1); wr(1, 3, 4, 1);
        step_to(HT - 1, VT - 1);
        wr(0, 0, 0, 20);
        chk("frame_b_hits", 32'(hitcnt[0]), 27);
        chk("frame_b_model", 32'(mism), 0);

        // Boundary write not yet active; video gated while the hit still registers.
        clr_hits(); mism = 0;
        step_to(98, 51);
        enable_out = 1'b0;
        step_to(102, 51);
        chk("hit_gated", 32'(spot_hit), 1);
        chk("video_gated", 32'(video_out), 0);
        step_to(115, 53);
        enable_out = 1'b1;
        step_to(0, 0);
        chk("frame_c_old_hpos", 32'(hitcnt[0]), 27);
        chk("far_spot_no_hit", 32'(hitcnt[1]), 0);
        chk("width1_no_hit", 32'(hitcnt[2]), 0);
        chk("height1_no_hit", 32'(hitcnt[3]), 0);
        chk("frame_c_model", 32'(mism), 0);

        clr_hits(); mism = 0;
        step_to(22, 51);
        chk("new_hpos_hit", 32'(spot_hit), 1);
        chk("new_hpos_video", 32'(video_out), 1);
        step_to(102, 51);
        chk("old_hpos_gone", 32'(spot_hit), 0);
        step_to(0, 0);
        chk("frame_d_hits", 32'(hitcnt[0]), 27);
        chk("frame_d_model", 32'(mism), 0);

        // Reset mid-line with a write in flight.
        step_to(50, 20);
        req_a_valid = 1'b1; req_a_idx = 2'd0; req_a_field = 3'd0; req_a_data = 11'd5;
        reset = 1'b1;
        #1;
        chk("rst_mid_h", 32'(h_cnt), 0);
        chk("rst_mid_v", 32'(v_cnt), 0);
        chk("rst_mid_hit", 32'(spot_hit), 0);
        chk("rst_mid_video", 32'(video_out), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold", 32'({h_cnt, v_cnt, spot_hit, video_out}), 0);
        req_a_valid = 1'b0;
        reset = 1'b0;
        clear_model();
        req_a_valid = 1'b1; req_b_valid = 1'b1;
        #1;
        chk("rst_ptr_a_first", 32'({req_a_ready, req_b_ready}), 2);
        req_a_valid = 1'b0; req_b_valid = 1'b0;
        clr_hits(); mism = 0;
        step();
        chk("h_after_rerelease", 32'(h_cnt), 1);
        step_to(0, 0);
        step_to(0, 55);
        chk("cleared_no_hits", 32'(hitcnt[0] + hitcnt[1] + hitcnt[2] + hitcnt[3]), 0);
        chk("post_reset_model", 32'(mism), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
